// File: rtl/regfile_dump_reader.sv
// Register file dump reader: halts the core, streams every register, releases.
// Optional trailing XOR checksum word when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  halt_ack_i,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    input  logic                  out_ready_i,
    output logic                  halt_req_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH:0]   out_index_o,
    output logic                  out_last_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HALT  = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] DONE  = 3'd5;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam logic [2:0] CSUM  = 3'd4;
    localparam logic [ADDR_WIDTH:0] CSUM_IDX = (ADDR_WIDTH+1)'(NUM_REGS);
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [ADDR_WIDTH-1:0] r_rf_addr;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ADDR_WIDTH:0]   r_out_index;
    logic                  r_out_last;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;
`endif

    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_hs;
    logic                  w_is_last;

    // x0 always reads as zero regardless of what the port returns
    assign w_word    = (r_index == '0) ? '0 : rf_data_i;
    assign w_hs      = r_out_valid && out_ready_i;
    assign w_is_last = (r_index == LAST_IDX);

    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);
    assign halt_req_o  = busy_o && !done_o;
    assign rf_addr_o   = r_rf_addr;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_index_o = r_out_index;
    assign out_last_o  = r_out_last;

    // Dump sequencer: state, index walk and output word register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_index     <= '0;
            r_rf_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    if (halt_ack_i) begin
                        r_rf_addr <= r_index;
                        r_state   <= FETCH;
                    end
                end
                FETCH: begin
                    r_out_data  <= w_word;
                    r_out_index <= {1'b0, r_index};
                    r_out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    r_out_last  <= 1'b0;
`else
                    r_out_last  <= w_is_last;
`endif
                    r_state     <= SEND;
                end
                SEND: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        if (!w_is_last) begin
                            r_index   <= r_index + 1'b1;
                            r_rf_addr <= r_index + 1'b1;
                            r_state   <= FETCH;
                        end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            r_state <= CSUM;
`else
                            r_state <= DONE;
`endif
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                // First cycle loads the checksum word, then waits for its handshake
                CSUM: begin
                    if (!r_out_valid) begin
                        r_out_data  <= r_csum;
                        r_out_index <= CSUM_IDX;
                        r_out_last  <= 1'b1;
                        r_out_valid <= 1'b1;
                    end else if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    r_index <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    // Running XOR of every emitted register word, cleared on each new dump
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= '0;
        end else if (r_state == IDLE && start_i) begin
            r_csum <= '0;
        end else if (r_state == FETCH) begin
            r_csum <= r_csum ^ w_word;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader.
// Build with +define+REGFILE_DUMP_CHECKSUM_EN to cover the checksum word.
module tb_regfile_dump_reader;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        halt_ack_i;
    logic [31:0] rf_data_i;
    logic        out_ready_i;
    logic        halt_req_o;
    logic [4:0]  rf_addr_o;
    logic        busy_o;
    logic        done_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic [5:0]  out_index_o;
    logic        out_last_o;

    int total = 0;
    int bad   = 0;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int WORDS = 33;
`else
    localparam int WORDS = 32;
`endif

    regfile_dump_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .halt_ack_i (halt_ack_i),
        .rf_data_i  (rf_data_i),
        .out_ready_i(out_ready_i),
        .halt_req_o (halt_req_o),
        .rf_addr_o  (rf_addr_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .out_valid_o(out_valid_o),
        .out_data_o (out_data_o),
        .out_index_o(out_index_o),
        .out_last_o (out_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: x0 returns junk the reader must mask
    always_comb begin
        rf_data_i = 32'h100 + {27'd0, rf_addr_o};
        if (rf_addr_o == 5'd0) rf_data_i = 32'hDEAD;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int n);
        if (n == 0) return 32'h0;
        if (n == 32) return 32'h100;
        return 32'h100 + n;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_halt"}, 64'(halt_req_o), 0);
        chk({tag, "_addr"}, 64'(rf_addr_o), 0);
        chk({tag, "_busy"}, 64'(busy_o), 0);
        chk({tag, "_done"}, 64'(done_o), 0);
        chk({tag, "_valid"}, 64'(out_valid_o), 0);
        chk({tag, "_data"}, 64'(out_data_o), 0);
        chk({tag, "_index"}, 64'(out_index_o), 0);
        chk({tag, "_last"}, 64'(out_last_o), 0);
    endtask

    // One full dump, called at a negedge with the DUT idle
    task automatic do_dump(input int stall_idx, input int stall_n,
                           input int ack_dly, input bit extra_starts);
        int  nxt = 0;
        int  stalls = 0;
        int  first_v = -1;
        int  done_cyc = -1;
        int  done_cnt = 0;
        bit  fin = 0;
        bit  rdy;
        start_i    = 1'b1;
        halt_ack_i = (ack_dly == 0);
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 1; cyc < 600; cyc++) begin
            if (done_cnt != 0) begin
                chk("idle_after_done", 64'(busy_o), 0);
                fin = 1;
                break;
            end
            if (ack_dly > 0 && cyc <= ack_dly) begin
                chk("halt_wait_req", 64'(halt_req_o), 1);
                chk("halt_wait_valid", 64'(out_valid_o), 0);
            end
            if (ack_dly > 0) halt_ack_i = (cyc >= ack_dly);
            start_i = extra_starts && (cyc % 7 == 3) && (cyc < 40);
            rdy = 1'b1;
            if (out_valid_o && int'(out_index_o) == stall_idx
                && stalls < stall_n) begin
                rdy = 1'b0;
                stalls++;
            end
            out_ready_i = rdy;
            if (out_valid_o) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    chk("halt_during_dump", 64'(halt_req_o), 1);
                end
                chk("word_index", 64'(out_index_o), 64'(nxt));
                chk("word_data", 64'(out_data_o), 64'(exp_word(nxt)));
                if (rdy) begin
                    chk("word_last", 64'(out_last_o), 64'(nxt == WORDS - 1));
                    nxt++;
                end
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_halt_rel", 64'(halt_req_o), 0);
                chk("done_busy", 64'(busy_o), 1);
                chk("done_word_cnt", 64'(nxt), 64'(WORDS));
            end
            @(negedge clk);
        end
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        chk("dump_finished", 64'(fin), 1);
        chk("done_pulses", 64'(done_cnt), 1);
        chk("stall_cycles", 64'(stalls), 64'(stall_n));
        chk("first_valid_cyc", 64'(first_v),
            64'((ack_dly == 0) ? 3 : ack_dly + 2));
        if (stall_n == 0 && ack_dly == 0)
            chk("done_cyc", 64'(done_cyc), 64'(2 + 2 * WORDS));
        chk("addr_hold", 64'(rf_addr_o), 31);
    endtask

    initial begin
        bit hit;
        rst         = 1'b0;
        start_i     = 1'b0;
        halt_ack_i  = 1'b1;
        out_ready_i = 1'b1;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 chk_idle_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_rst");

        // Plain dump, no backpressure
        do_dump(-1, 0, 0, 1'b0);
        @(negedge clk);

        // Backpressure on index 3 for five cycles
        do_dump(3, 5, 0, 1'b0);
        @(negedge clk);

        // Late halt acknowledge plus stray start pulses while busy
        do_dump(-1, 0, 10, 1'b1);
        halt_ack_i = 1'b1;
        @(negedge clk);
        chk("no_second_dump", 64'(busy_o), 0);

        // Reset while index 10 is on the stream
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid_o && out_index_o == 6'd10) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_idx10", 64'(hit), 1);
        rst = 1'b1;
        #1 chk("mid_rst_halt", 64'(halt_req_o), 0);
        chk("mid_rst_valid", 64'(out_valid_o), 0);
        chk("mid_rst_busy", 64'(busy_o), 0);
        chk("mid_rst_data", 64'(out_data_o), 0);
        chk("mid_rst_index", 64'(out_index_o), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_dump(-1, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
